// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding and control-vector layout for pipeline control blocks
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  // Control vector bit order: {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f}
  typedef logic [6:0] ctrl_vec_t;

  localparam int CTRL_PC       = 6;
  localparam int CTRL_IF_ID_W  = 5;
  localparam int CTRL_IF_ID_F  = 4;
  localparam int CTRL_ID_EX_W  = 3;
  localparam int CTRL_ID_EX_F  = 2;
  localparam int CTRL_EX_MEM_W = 1;
  localparam int CTRL_MEM_WB_F = 0;

  localparam ctrl_vec_t CTRL_RESET  = 7'b0010101;
  localparam ctrl_vec_t CTRL_RUN    = 7'b1101010;
  localparam ctrl_vec_t CTRL_FREEZE = 7'b0000001;
  localparam ctrl_vec_t CTRL_HALT   = 7'b0000000;

  // Redirect outranks hazard: the ID instruction is wrong-path, so its stall is moot.
  function automatic ctrl_vec_t run_ctrl(input logic redirect, input logic hazard,
                                         input logic imem_ready);
    ctrl_vec_t c;
    c = CTRL_RUN;
    if (redirect) begin
      c[CTRL_IF_ID_F] = 1'b1;
      c[CTRL_ID_EX_F] = 1'b1;
    end else if (hazard) begin
      c[CTRL_PC]      = 1'b0;
      c[CTRL_IF_ID_W] = 1'b0;
      c[CTRL_ID_EX_F] = 1'b1;
    end else if (!imem_ready) begin
      c[CTRL_PC]      = 1'b0;
      c[CTRL_IF_ID_F] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// rtl/pipeline_ctrl_perf_counter.sv - enable-gated wrapping event counter
module pipeline_ctrl_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush scheduler with data-memory wait watchdog
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hazard,
  input  logic             redirect,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       bus_err_nxt;
  logic       flush_inc;
  logic       stall_inc;
  ctrl_vec_t  ctrl;

  always_comb begin
    ctrl        = CTRL_RESET;
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    bus_err_nxt = bus_err;
    flush_inc   = 1'b0;
    if (rstn) begin
      case (state)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = ST_MEM_WAIT;
            wait_nxt  = 8'd1;
          end else begin
            ctrl      = run_ctrl(redirect, hazard, imem_ready);
            flush_inc = redirect;
          end
        end
        ST_MEM_WAIT: begin
          // A dropped request without ready is treated as completion.
          if (dmem_ready || !dmem_req) begin
            ctrl      = run_ctrl(redirect, hazard, imem_ready);
            flush_inc = redirect;
            state_nxt = ST_RUN;
            wait_nxt  = 8'd0;
          end else begin
            ctrl = CTRL_FREEZE;
            if (wait_cnt == 8'(TIMEOUT - 1)) begin
              state_nxt   = ST_ERR;
              bus_err_nxt = 1'b1;
            end else begin
              wait_nxt = wait_cnt + 8'd1;
            end
          end
        end
        default: ctrl = CTRL_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_RUN;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

  assign pc_write     = ctrl[CTRL_PC];
  assign if_id_write  = ctrl[CTRL_IF_ID_W];
  assign if_id_flush  = ctrl[CTRL_IF_ID_F];
  assign id_ex_write  = ctrl[CTRL_ID_EX_W];
  assign id_ex_flush  = ctrl[CTRL_ID_EX_F];
  assign ex_mem_write = ctrl[CTRL_EX_MEM_W];
  assign mem_wb_flush = ctrl[CTRL_MEM_WB_F];

  assign stall_inc = rstn && (state != ST_ERR) && !ctrl[CTRL_PC];

  pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (stall_inc),
    .cnt  (stall_cnt)
  );

  pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (flush_inc),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard testbench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  // {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f}
  localparam logic [6:0] V_RST = 7'b0010101;
  localparam logic [6:0] V_RUN = 7'b1101010;
  localparam logic [6:0] V_FRZ = 7'b0000001;
  localparam logic [6:0] V_RED = 7'b1111110;
  localparam logic [6:0] V_HAZ = 7'b0001110;
  localparam logic [6:0] V_IMS = 7'b0111010;
  localparam logic [6:0] V_ERR = 7'b0000000;

  logic clk = 1'b0;
  logic rstn, hazard, redirect, imem_ready, dmem_req, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
  logic bus_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctrl_act;

  typedef struct {
    int         id;
    logic [6:0] ctrl;
    logic       berr;
    logic [3:0] stall;
    logic [3:0] flush;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  assign ctrl_act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                     ex_mem_write, mem_wb_flush};

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .hazard       (hazard),
    .redirect     (redirect),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_write (ex_mem_write),
    .mem_wb_flush (mem_wb_flush),
    .bus_err      (bus_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // Apply one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic r, input logic h, input logic rd, input logic im,
                      input logic dq, input logic dr, input logic [6:0] c,
                      input logic b, input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = r; hazard = h; redirect = rd; imem_ready = im; dmem_req = dq; dmem_ready = dr;
    e.id = step_id; e.ctrl = c; e.berr = b; e.stall = 4'(s); e.flush = 4'(f);
    sb.push_back(e);
    step_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({ctrl_act, bus_err, stall_cnt, flush_cnt} !== {e.ctrl, e.berr, e.stall, e.flush}) begin
          failures++;
          $display("FAIL step%0d: got ctrl=%b bus_err=%b stall=%0d flush=%0d, expected ctrl=%b bus_err=%b stall=%0d flush=%0d",
                   e.id, ctrl_act, bus_err, stall_cnt, flush_cnt, e.ctrl, e.berr, e.stall, e.flush);
        end
      end
    end
  end

  initial begin : driver
    rstn = 1'b0; hazard = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
    dmem_req = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    //   rstn hz rd im dq dr  ctrl   berr stall flush
    step(0, 0, 0, 1, 0, 0, V_RST, 0, 0, 0);   // reset outputs
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, V_HAZ, 0, 0, 0);   // load-use
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 1, 0);
    step(1, 1, 1, 1, 0, 0, V_RED, 0, 1, 0);   // redirect beats hazard
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, V_IMS, 0, 1, 1);   // imem miss x2
    step(1, 0, 0, 0, 0, 0, V_IMS, 0, 2, 1);
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 3, 1);
    step(1, 0, 1, 1, 1, 0, V_FRZ, 0, 3, 1);   // dmem wait with redirect held
    step(1, 0, 1, 1, 1, 0, V_FRZ, 0, 4, 1);
    step(1, 0, 1, 1, 1, 0, V_FRZ, 0, 5, 1);
    step(1, 0, 1, 1, 1, 1, V_RED, 0, 6, 1);   // release applies redirect
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 6, 2);
    step(1, 0, 1, 0, 0, 0, V_RED, 0, 6, 2);   // redirect with imem miss
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 6, 3);
    step(1, 0, 0, 1, 1, 0, V_FRZ, 0, 6, 3);   // request dropped without ready
    step(1, 1, 0, 1, 0, 0, V_HAZ, 0, 7, 3);
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 8, 3);
    step(1, 0, 0, 1, 1, 0, V_FRZ, 0, 8, 3);   // watchdog, TIMEOUT=4
    step(1, 0, 0, 1, 1, 0, V_FRZ, 0, 9, 3);
    step(1, 0, 0, 1, 1, 0, V_FRZ, 0, 10, 3);
    step(1, 0, 0, 1, 1, 0, V_FRZ, 0, 11, 3);
    step(1, 0, 0, 1, 1, 0, V_ERR, 1, 12, 3);
    step(1, 1, 1, 0, 1, 1, V_ERR, 1, 12, 3);  // ERR ignores everything
    step(1, 0, 0, 1, 0, 0, V_ERR, 1, 12, 3);
    step(0, 0, 0, 1, 0, 0, V_RST, 1, 12, 3);
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 0, 0);   // reset cleared error and counters
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 0, 1, 0, 0, V_HAZ, 0, i % 16, 0);
    end
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 1, 0);   // 17 stalls wrap to 1
    step(1, 0, 0, 1, 1, 0, V_FRZ, 0, 1, 0);   // reset while waiting on dmem
    step(0, 0, 0, 1, 1, 0, V_RST, 0, 2, 0);
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, V_RED, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, V_RUN, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It combines the load-use hazard flag, the EX-stage branch/jump redirect, and the instruction/data memory ready handshakes into per-stage write-enable and flush controls. It also runs a data-memory wait state machine with a watchdog, and keeps stall/flush performance counters. It sits in the CPU top, between the hazard detector, the memory interfaces and the four pipeline registers.

Parameters:
TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before bus error (range 2..255)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  core clock, rising edge
rstn  input  1  synchronous active-low reset
hazard  input  1  load-use hazard from the hazard detector (ID vs EX)
redirect  input  1  EX-stage taken branch/jump; PC mux selects the target
imem_ready  input  1  instruction fetch completes this cycle
dmem_req  input  1  MEM-stage load/store active
dmem_ready  input  1  data access completes this cycle
pc_write  output  1  PC register enable
if_id_write  output  1  IF/ID enable
if_id_flush  output  1  IF/ID load bubble
id_ex_write  output  1  ID/EX enable
id_ex_flush  output  1  ID/EX load bubble
ex_mem_write  output  1  EX/MEM enable
mem_wb_flush  output  1  MEM/WB load bubble
bus_err  output  1  sticky data-bus timeout
stall_cnt  output  CNT_W  cycles with pc_write=0 (excluding reset and ERR)
flush_cnt  output  CNT_W  redirect flushes taken

Behaviour:
- Reset: clk and rstn are fixed as stated. Reset is synchronous and active-low. While rstn=0 is sampled: state<=RUN, wait_cnt<=0, bus_err<=0, counters<=0.
- Control outputs are combinational from state and inputs (zero latency). While rstn=0: all write enables are 0 and all flushes are 1.
- Default in RUN: all writes 1, all flushes 0.
- States: RUN, MEM_WAIT, ERR.
- RUN priority, highest first:
  - (a) dmem_req && !dmem_ready: freeze PC, IF/ID, ID/EX and EX/MEM (enables 0, flushes 0); mem_wb_flush=1. Next state MEM_WAIT, wait_cnt<=1.
  - (b) redirect: pc_write=1, if_id_flush=1, id_ex_flush=1. flush_cnt++. hazard is ignored, because the ID instruction is wrong-path.
  - (c) hazard: pc_write=0, if_id_write=0, id_ex_flush=1.
  - (d) !imem_ready: pc_write=0, if_id_flush=1 (bubble). Downstream stages advance.
- (b) combined with !imem_ready: the redirect still loads the PC. if_id_flush=1. No state change.
- MEM_WAIT:
  - Freeze outputs identical to (a); redirect and hazard are ignored. The EX instruction is frozen, so redirect re-presents after exit.
  - dmem_ready=1: release this cycle with RUN priority (b)-(d) applied. Next state RUN, wait_cnt<=0.
  - Else wait_cnt++. If wait_cnt==TIMEOUT-1 and still not ready: next state ERR, bus_err<=1.
  - dmem_req dropping without ready is a protocol error; treat it as ready.
- ERR: all enables 0, all flushes 0, bus_err=1. Counters freeze. Exit only via reset.
- stall_cnt increments in any non-reset, non-ERR cycle with pc_write=0. Both counters wrap modulo 2^CNT_W.
- Reset asserted in MEM_WAIT or ERR: the next cycle is RUN with bus_err=0.

Decomposition:
- Shared package: state encoding localparams (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the control-vector bit order {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f}. Other control blocks reuse these.
- One sub-module, perf_counter: enable-gated, wrapping CNT_W counter with synchronous active-low reset, instantiated twice.

Test Plan:
- Load-use: hazard=1 for one cycle, all else idle and ready -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all writes 1; stall_cnt=1.
- Redirect plus hazard in the same cycle -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1; flush_cnt=1; stall_cnt unchanged.
- dmem_req=1 with dmem_ready low for 3 cycles then high, and redirect=1 throughout -> 3 cycles frozen with mem_wb_flush=1; the release cycle shows flushes asserted; state back in RUN; stall_cnt=3, flush_cnt=1.
- TIMEOUT=4, dmem_ready never asserts -> bus_err=1 after the 4th MEM_WAIT cycle; all enables 0; counters frozen; rstn=0 for one edge clears bus_err and counters.
- imem_ready=0 for 2 cycles with no hazards -> pc_write=0, if_id_flush=1, id_ex_write=1 each cycle; stall_cnt=2.
- CNT_W=4, 17 load-use stalls -> stall_cnt wraps to 1.
